// File: rtl/seq_pair_tx.sv
// Two-wire symbol transmitter feeding the x1/x2 sequence detector pair.
// Optional even-parity slot enabled by defining SEQ_PAIR_TX_PARITY_EN.
module seq_pair_tx #(
  parameter int DATA_W   = 8,
  parameter int SLOT_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              x1,
  output logic              x2,
  output logic              busy
);

  localparam int CW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_GUARD,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state, nxt_state;
  logic [CW-1:0]     cnt, nxt_cnt;
  logic [IW-1:0]     idx, nxt_idx;
  logic [DATA_W-1:0] sh, nxt_sh;
  logic              flag, nxt_flag;
  logic              nxt_x1, nxt_x2;
  logic              slot_end;
`ifdef SEQ_PAIR_TX_PARITY_EN
  logic              par_q;
`endif

  assign slot_end = (cnt == CNT_LAST);
  assign tx_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      flag  <= 1'b0;
      x1    <= 1'b0;
      x2    <= 1'b0;
`ifdef SEQ_PAIR_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      idx   <= nxt_idx;
      sh    <= nxt_sh;
      flag  <= nxt_flag;
      x1    <= nxt_x1;
      x2    <= nxt_x2;
`ifdef SEQ_PAIR_TX_PARITY_EN
      if (tx_ready && tx_valid)
        par_q <= ^tx_data;
`endif
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    nxt_sh    = sh;
    nxt_flag  = flag;
    if (state != S_IDLE)
      nxt_cnt = slot_end ? '0 : cnt + 1'b1;
    unique case (state)
      S_IDLE: begin
        if (tx_valid) begin
          nxt_state = S_START;
          nxt_sh    = tx_data;
          nxt_flag  = 1'b0;
          nxt_cnt   = '0;
          nxt_idx   = '0;
        end
      end
      S_START:
        if (slot_end) nxt_state = S_GUARD;
      S_GUARD:
        if (slot_end) nxt_state = S_DATA;
      S_DATA: begin
        if (slot_end) begin
          // flag flips after each one so repeated ones still toggle a line
          nxt_sh   = sh << 1;
          nxt_flag = flag ^ sh[DATA_W-1];
          nxt_idx  = idx + 1'b1;
          if (idx == IDX_LAST) begin
            nxt_idx   = '0;
`ifdef SEQ_PAIR_TX_PARITY_EN
            nxt_state = S_PARITY;
`else
            nxt_state = S_STOP;
`endif
          end
        end
      end
`ifdef SEQ_PAIR_TX_PARITY_EN
      S_PARITY: begin
        if (slot_end) begin
          nxt_flag  = flag ^ par_q;
          nxt_state = S_STOP;
        end
      end
`endif
      S_STOP:
        if (slot_end) nxt_state = S_IDLE;
      default:
        nxt_state = S_IDLE;
    endcase
  end

  // Symbol for the state being entered, so lines move with the state edge
  always_comb begin
    nxt_x1 = 1'b0;
    nxt_x2 = 1'b0;
    unique case (1'b1)
      (nxt_state == S_START),
      (nxt_state == S_STOP): begin
        nxt_x1 = 1'b1;
        nxt_x2 = 1'b1;
      end
      (nxt_state == S_DATA): begin
        if (nxt_sh[DATA_W-1]) begin
          nxt_x1 = nxt_flag;
          nxt_x2 = ~nxt_flag;
        end
      end
`ifdef SEQ_PAIR_TX_PARITY_EN
      (nxt_state == S_PARITY): begin
        if (par_q) begin
          nxt_x1 = nxt_flag;
          nxt_x2 = ~nxt_flag;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule
